// File: rtl/cla_shift_add_multiplier.sv
// rtl/cla_shift_add_multiplier.sv - sequential shift-and-add multiplier built on a carry-lookahead adder (optional MULT_EARLY_TERM_EN)

module CarryLookAheadAdderContinuousAssigment #(
    parameter int Nbits = 16
) (
    input  logic [Nbits-1:0] a_in,
    input  logic [Nbits-1:0] b_in,
    input  logic             cin,
    output logic [Nbits-1:0] sum,
    output logic             cout
);
    logic [Nbits-1:0] w_g;
    logic [Nbits-1:0] w_p;
    logic [Nbits:0]   w_c;

    assign w_g    = a_in & b_in;
    assign w_p    = a_in ^ b_in;
    assign w_c[0] = cin;

    // Each carry is expressed from generate/propagate terms; synthesis flattens the lookahead
    for (genvar i = 0; i < Nbits; i++) begin : g_carry
        assign w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
    end

    assign sum  = w_p ^ w_c[Nbits-1:0];
    assign cout = w_c[Nbits];
endmodule

module cla_shift_add_multiplier #(
    parameter int Nbits = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [Nbits-1:0]   a_in,
    input  logic [Nbits-1:0]   b_in,
    output logic               busy,
    output logic               done,
    output logic [2*Nbits-1:0] product
);
    localparam int CW = $clog2(Nbits) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(Nbits - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [Nbits-1:0]   r_mcand;
    logic [2*Nbits-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [2*Nbits-1:0] r_product;

    logic [Nbits-1:0]   w_add_b;
    logic [Nbits-1:0]   w_sum;
    logic               w_cout;
    logic [2*Nbits-1:0] w_next_acc;
    logic               w_early;

    // Add the multiplicand only when the current multiplier bit (acc LSB) is set
    assign w_add_b = r_acc[0] ? r_mcand : '0;

    CarryLookAheadAdderContinuousAssigment #(.Nbits(Nbits)) u_adder (
        .a_in (r_acc[2*Nbits-1:Nbits]),
        .b_in (w_add_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Carry-out lands in the top bit as the 2N+1-bit sum shifts right by one
    assign w_next_acc = {w_cout, w_sum, r_acc[Nbits-1:1]};

`ifdef MULT_EARLY_TERM_EN
    assign w_early = (a_in == '0) || (b_in == '0);
`else
    assign w_early = 1'b0;
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

    // Control FSM with datapath registers; done is a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && w_early) begin
                        r_product <= '0;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end else if (start) begin
                        r_mcand <= a_in;
                        r_acc   <= {{Nbits{1'b0}}, b_in};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_acc <= w_next_acc;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER) begin
                        r_product <= w_next_acc;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cla_shift_add_multiplier.sv
// tb/tb_cla_shift_add_multiplier.sv - directed and swept checks of cla_shift_add_multiplier

module tb_cla_shift_add_multiplier;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_vec;
    int n_miss;

    cla_shift_add_multiplier #(.Nbits(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge; the following edge is the start edge
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done, and samples where busy is high
    task automatic wait_done(output int cyc, output int busy_n);
        cyc    = 0;
        busy_n = busy ? 1 : 0;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (busy) busy_n++;
        end
        if (!done) check("timeout", 64'(done), 64'd1);
    endtask

    task automatic run_and_check(input string tag, input logic [15:0] a, input logic [15:0] b);
        int cyc;
        int bn;
        logic [31:0] exp;
        exp = {16'd0, a} * {16'd0, b};
        start_op(a, b);
        wait_done(cyc, bn);
        check(tag, 64'(product), 64'(exp));
    endtask

    initial begin
        int cyc;
        int bn;
        logic [15:0] ra;
        logic [15:0] rb;
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        a_in   = '0;
        b_in   = '0;

        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'd0);

        // 3 * 5: latency, busy length and hold
        start_op(16'd3, 16'd5);
        check("e0_busy", 64'(busy), 64'd1);
        wait_done(cyc, bn);
        check("lat_3x5", 64'(cyc), 64'd16);
        check("busy_len_3x5", 64'(bn), 64'd16);
        check("prod_3x5", 64'(product), 64'h0000000F);
        @(posedge clk);
        #1;
        check("done_pulse", 64'(done), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_3x5", 64'(product), 64'h0000000F);

        run_and_check("prod_ffff", 16'hFFFF, 16'hFFFF);
        check("prod_ffff_k", 64'(product), 64'hFFFE0001);
        run_and_check("prod_8000x2", 16'h8000, 16'h0002);
        check("prod_8000x2_k", 64'(product), 64'h00010000);
        @(posedge clk);
        #1;

        // Zero operand
        start_op(16'h0000, 16'h1234);
        wait_done(cyc, bn);
`ifdef MULT_EARLY_TERM_EN
        check("zero_lat", 64'(cyc), 64'd0);
        check("zero_busy", 64'(bn), 64'd0);
`else
        check("zero_lat", 64'(cyc), 64'd16);
        check("zero_busy", 64'(bn), 64'd16);
`endif
        check("zero_prod", 64'(product), 64'd0);
        @(posedge clk);
        #1;

        // Starts while running are ignored
        start_op(16'd1000, 16'd3);
        cyc = 0;
        while (!done && cyc < 40) begin
            if (cyc == 3 || cyc == 10) begin
                start = 1'b1;
                a_in  = 16'hFFFF;
                b_in  = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        check("ign_lat", 64'(cyc), 64'd16);
        check("ign_prod", 64'(product), 64'd3000);

        // Back-to-back start during the done cycle
        start_op(16'd7, 16'd9);
        check("b2b_done_drop", 64'(done), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_old_prod", 64'(product), 64'd3000);
        wait_done(cyc, bn);
        check("b2b_lat", 64'(cyc), 64'd16);
        check("b2b_prod", 64'(product), 64'd63);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-run
        start_op(16'd100, 16'd200);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_and_check("post_rst_2x2", 16'd2, 16'd2);
        check("post_rst_k", 64'(product), 64'd4);

        // Corners: one-hot against all-ones and one-hot squared
        for (int i = 0; i < 16; i++) begin
            ra = 16'd1 << i;
            run_and_check("onehot_ff", ra, 16'hFFFF);
            run_and_check("onehot_sq", ra, ra);
        end
        run_and_check("ones_one", 16'hFFFF, 16'h0001);

        // Random sweep, back-to-back through the done cycle
        for (int k = 0; k < 1500; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_and_check("rand", ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
